sram_access_arbiter: RTL and testbench

- Sequences the on-chip 2048x8 SRAM through its enable / readwrite / address / datain / dataout interface.
- Shares the SRAM between two requesters: port 0 is the processor-side PIO bridge, port 1 is a hardware client.
- Round-robin arbitration grants one transaction at a time.
- Each transaction completes with a one-cycle ack; reads return data with that ack.

---
 rtl/sram_arb_pkg.sv | 17 +
 rtl/sram_access_arbiter_rr_arbiter2.sv | 24 ++
 rtl/sram_access_arbiter.sv | 127 ++++++++++++
 tb/tb_sram_access_arbiter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-port SRAM access arbiter.
package sram_arb_pkg;

  localparam int ADDR_W_DEF = 11;
  localparam int DATA_W_DEF = 8;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    DONE
  } state_t;

endpackage

// File: rtl/sram_access_arbiter_rr_arbiter2.sv
// Two-way round-robin pick: a lone requester always wins, a tie goes to ptr.
module rr_arbiter2 (
  input  logic       req0,
  input  logic       req1,
  input  logic       ptr,
  output logic [1:0] grant,
  output logic       win_id
);

  always_comb begin
    grant  = 2'b00;
    win_id = 1'b0;
    if (req0 && req1) begin
      win_id = ptr;
      grant  = ptr ? 2'b10 : 2'b01;
    end else if (req0) begin
      grant = 2'b01;
    end else if (req1) begin
      grant  = 2'b10;
      win_id = 1'b1;
    end
  end

endmodule

// File: rtl/sram_access_arbiter.sv
// Shares a single-port SRAM between a PIO bridge (port 0) and a hardware
// client (port 1); one transaction at a time, completed by a one-cycle ack.
module sram_access_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int READ_LAT = 1
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  // Handshake: reqN rises with weN/addrN/wdataN stable and stays high until
  // ackN pulses for one cycle; dropping it early does not cancel the access.
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              busy,
  output logic              sram_en,
  output logic              sram_rw,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_din,
  input  logic [DATA_W-1:0] sram_dout,
  output state_t            state_dbg
);

  localparam logic [1:0] LAT_INIT = 2'(READ_LAT);

  state_t      state;
  logic        ptr;
  logic        win_q;
  logic        we_q;
  logic [1:0]  wait_cnt;
  logic [1:0]  grant;
  logic        win_id;
  logic        sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  rr_arbiter2 u_arb (
    .req0   (req0),
    .req1   (req1),
    .ptr    (ptr),
    .grant  (grant),
    .win_id (win_id)
  );

  assign sel_we    = win_id ? we1    : we0;
  assign sel_addr  = win_id ? addr1  : addr0;
  assign sel_wdata = win_id ? wdata1 : wdata0;

  assign busy      = (state != IDLE);
  assign state_dbg = state;

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state     <= IDLE;
      ptr       <= 1'b0;
      win_q     <= 1'b0;
      we_q      <= 1'b0;
      wait_cnt  <= 2'd0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
      sram_en   <= 1'b0;
      sram_rw   <= RW_READ;
      sram_addr <= '0;
      sram_din  <= '0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state)
        IDLE: begin
          if (|grant) begin
            win_q     <= win_id;
            we_q      <= sel_we;
            sram_en   <= 1'b1;
            sram_rw   <= sel_we ? RW_WRITE : RW_READ;
            sram_addr <= sel_addr;
            sram_din  <= sel_we ? sel_wdata : '0;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          sram_en  <= 1'b0;
          sram_din <= '0;
          if (we_q) begin
            ack0  <= ~win_q;
            ack1  <= win_q;
            state <= DONE;
          end else begin
            wait_cnt <= LAT_INIT;
            state    <= WAIT;
          end
        end
        WAIT: begin
          wait_cnt <= wait_cnt - 2'd1;
          // Last wait cycle is exactly READ_LAT after the enable cycle.
          if (wait_cnt == 2'd1) begin
            if (win_q) rdata1 <= sram_dout;
            else       rdata0 <= sram_dout;
            ack0  <= ~win_q;
            ack1  <= win_q;
            state <= DONE;
          end
        end
        DONE: begin
          ptr       <= ~win_q;
          sram_rw   <= RW_READ;
          sram_addr <= '0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Directed bench for sram_access_arbiter with READ_LAT=1 and READ_LAT=3 builds.
module tb_sram_access_arbiter;
  import sram_arb_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- READ_LAT=1 instance ----------------
  logic        req0 = 0, req1 = 0, we0 = 0, we1 = 0;
  logic [10:0] addr0 = 0, addr1 = 0;
  logic [7:0]  wdata0 = 0, wdata1 = 0;
  logic        ack0, ack1, busy, sram_en, sram_rw;
  logic [7:0]  rdata0, rdata1, sram_din;
  logic [7:0]  sram_dout = 8'h00;
  logic [10:0] sram_addr;
  state_t      st;

  sram_access_arbiter #(.READ_LAT(1)) u_dut (
    .clk_clk(clk), .reset_reset(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .busy(busy), .sram_en(sram_en), .sram_rw(sram_rw),
    .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout),
    .state_dbg(st)
  );

  // SRAM model: data valid only in the single cycle READ_LAT after enable
  logic [7:0] mem [0:2047];
  always @(posedge clk) begin
    if (sram_en && !sram_rw) mem[sram_addr] <= sram_din;
    sram_dout <= (sram_en && sram_rw) ? mem[sram_addr] : 8'h00;
  end

  // ---------------- READ_LAT=3 instance ----------------
  logic        req0_3 = 0, req1_3 = 0, we0_3 = 0, we1_3 = 0;
  logic [10:0] addr0_3 = 0, addr1_3 = 0;
  logic [7:0]  wdata0_3 = 0, wdata1_3 = 0;
  logic        ack0_3, ack1_3, busy_3, sram_en_3, sram_rw_3;
  logic [7:0]  rdata0_3, rdata1_3, sram_din_3;
  logic [10:0] sram_addr_3;
  state_t      st_3;
  logic [7:0]  pipe3_0 = 0, pipe3_1 = 0, pipe3_2 = 0;

  sram_access_arbiter #(.READ_LAT(3)) u_dut3 (
    .clk_clk(clk), .reset_reset(rst),
    .req0(req0_3), .req1(req1_3), .we0(we0_3), .we1(we1_3),
    .addr0(addr0_3), .addr1(addr1_3), .wdata0(wdata0_3), .wdata1(wdata1_3),
    .ack0(ack0_3), .ack1(ack1_3), .rdata0(rdata0_3), .rdata1(rdata1_3),
    .busy(busy_3), .sram_en(sram_en_3), .sram_rw(sram_rw_3),
    .sram_addr(sram_addr_3), .sram_din(sram_din_3), .sram_dout(pipe3_2),
    .state_dbg(st_3)
  );

  logic [7:0] mem3 [0:2047];
  always @(posedge clk) begin
    if (sram_en_3 && !sram_rw_3) mem3[sram_addr_3] <= sram_din_3;
    pipe3_0 <= (sram_en_3 && sram_rw_3) ? mem3[sram_addr_3] : 8'h00;
    pipe3_1 <= pipe3_0;
    pipe3_2 <= pipe3_1;
  end

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];
  int         gnt_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int p, input logic we, input logic [10:0] a, input logic [7:0] d);
    if (p == 0) begin req0 = 1; we0 = we; addr0 = a; wdata0 = d; end
    else        begin req1 = 1; we1 = we; addr1 = a; wdata1 = d; end
  endtask

  task automatic clear_req(input int p);
    if (p == 0) req0 = 0;
    else        req1 = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    repeat (3) tick();
    rst = 0;
  endtask

  // Single transaction from IDLE; lat = cycles from request sample to ack.
  task automatic do_txn(input int p, input logic we, input logic [10:0] a,
                        input logic [7:0] d, input int lat, input logic [7:0] exp_rd);
    bit got = 0;
    logic own_ack, oth_ack;
    if (!we) exp_q.push_back(exp_rd);
    set_req(p, we, a, d);
    tick();
    check("en_cycle_en",   sram_en, 1);
    check("en_cycle_rw",   sram_rw, !we);
    check("en_cycle_addr", sram_addr, a);
    check("en_cycle_din",  sram_din, we ? d : 8'h00);
    for (int cyc = 2; cyc <= 8 && !got; cyc++) begin
      tick();
      own_ack = (p == 0) ? ack0 : ack1;
      oth_ack = (p == 0) ? ack1 : ack0;
      check("other_ack", oth_ack, 0);
      check("en_low", sram_en, 0);
      if (own_ack) begin
        got = 1;
        check("ack_latency", cyc, lat);
        if (!we) check("rdata", (p == 0) ? rdata0 : rdata1, exp_q.pop_front());
      end
    end
    if (!got) begin
      check("ack_timeout", 0, 1);
      if (!we) void'(exp_q.pop_front());
    end
    clear_req(p);
    tick();
    check("idle_busy", busy, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int nack;
    bit got;
    mem3[11'h123] = 8'h5A;

    do_reset();
    check("rst_busy", busy, 0);
    check("rst_en",   sram_en, 0);
    check("rst_rw",   sram_rw, 1);
    check("rst_addr", sram_addr, 0);
    check("rst_din",  sram_din, 0);
    check("rst_ack",  {ack1, ack0}, 0);
    check("rst_rdata", {rdata1, rdata0}, 0);
    check("rst_state", st, IDLE);

    // Write then read the same word from the other port
    do_txn(0, 1'b1, 11'h005, 8'hA5, 2, 8'h00);
    do_txn(1, 1'b0, 11'h005, 8'h00, 3, 8'hA5);

    // Boundary addresses
    do_txn(0, 1'b1, 11'h7FF, 8'hFF, 2, 8'h00);
    do_txn(1, 1'b1, 11'h000, 8'h3C, 2, 8'h00);
    do_txn(0, 1'b0, 11'h7FF, 8'h00, 3, 8'hFF);
    do_txn(1, 1'b0, 11'h000, 8'h00, 3, 8'h3C);
    check("rdata0_held", rdata0, 8'hFF);

    // Full load from reset: strict alternation starting at port 0
    do_reset();
    gnt_q = '{0, 1, 0, 1};
    set_req(0, 1'b1, 11'h010, 8'h11);
    set_req(1, 1'b1, 11'h020, 8'h22);
    nack = 0;
    for (int cyc = 1; cyc <= 16 && nack < 4; cyc++) begin
      tick();
      check("ack_overlap", ack0 & ack1, 0);
      if (sram_en && gnt_q.size() > 0)
        check("alt_addr", sram_addr, (gnt_q[0] == 0) ? 11'h010 : 11'h020);
      if (ack0 || ack1) begin
        check("alt_port", ack1 ? 1 : 0, gnt_q.pop_front());
        check("alt_cycle", cyc, 2 + 3 * nack);
        nack++;
      end
    end
    check("alt_count", nack, 4);
    clear_req(0);
    clear_req(1);
    tick();

    // Reset during the WAIT of a port 0 read
    set_req(0, 1'b0, 11'h005, 8'h00);
    tick();
    tick();
    check("mid_state_wait", st, WAIT);
    rst = 1;
    clear_req(0);
    tick();
    rst = 0;
    check("mid_rst_state", st, IDLE);
    check("mid_rst_busy",  busy, 0);
    check("mid_rst_en",    sram_en, 0);
    check("mid_rst_rw",    sram_rw, 1);
    check("mid_rst_addr",  sram_addr, 0);
    check("mid_rst_rdata", rdata0, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("no_ack_after_rst", {ack1, ack0}, 0);
    end
    set_req(0, 1'b1, 11'h040, 8'h44);
    set_req(1, 1'b1, 11'h050, 8'h55);
    got = 0;
    for (int cyc = 1; cyc <= 6 && !got; cyc++) begin
      tick();
      if (ack0 || ack1) begin
        got = 1;
        check("post_rst_first", {ack1, ack0}, 2'b01);
        check("post_rst_cycle", cyc, 2);
      end
    end
    if (!got) check("post_rst_timeout", 0, 1);
    clear_req(0);
    clear_req(1);
    tick();

    // READ_LAT=3 build
    req0_3 = 1; we0_3 = 0; addr0_3 = 11'h123;
    tick();
    check("lat3_en",   sram_en_3, 1);
    check("lat3_rw",   sram_rw_3, 1);
    check("lat3_addr", sram_addr_3, 11'h123);
    got = 0;
    for (int cyc = 2; cyc <= 10 && !got; cyc++) begin
      tick();
      check("lat3_ack1", ack1_3, 0);
      if (ack0_3) begin
        got = 1;
        check("lat3_latency", cyc, 5);
        check("lat3_rdata", rdata0_3, 8'h5A);
      end
    end
    if (!got) check("lat3_timeout", 0, 1);
    req0_3 = 0;
    tick();
    check("lat3_idle", busy_3, 0);

    check("exp_q_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
